// File: rtl/round_engine_pkg.sv
// Shared definitions for the round engine: FSM encoding and round constants.
// Used by round_engine and round_fn.
package round_engine_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int ROT_AMT = 3;

endpackage

// File: rtl/round_fn.sv
// One combinational cipher round: t = x ^ rep(rk); y = rotl(t,ROT_AMT) + t.
// Pure logic, no state.
import round_engine_pkg::*;

module round_fn #(
   parameter int DATA_W = 32,
   parameter int KEY_W  = 8
) (
   input  logic [DATA_W-1:0] i_state,
   input  logic [KEY_W-1:0]  i_rk,
   output logic [DATA_W-1:0] o_state
);

   logic [DATA_W-1:0] w_t;
   logic [DATA_W-1:0] w_rot;

   // Whiten with the replicated key, then rotate-and-add mix
   always_comb begin
      w_t     = i_state ^ {(DATA_W / KEY_W){i_rk}};
      w_rot   = {w_t[DATA_W-1-ROT_AMT:0], w_t[DATA_W-1:DATA_W-ROT_AMT]};
      o_state = w_rot + w_t;
   end

endmodule

// File: rtl/round_engine.sv
// Iterative round engine with valid/ready block handshake.
// Define ROUND_ENGINE_UNROLL2_EN to apply two chained rounds per cycle.
import round_engine_pkg::*;

module round_engine #(
   parameter int DATA_W     = 32,
   parameter int KEY_W      = 8,
   parameter int NUM_ROUNDS = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] D_IN,
   input  logic [KEY_W-1:0]  K_IN,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] D_OUT,
   output logic              BUSY
);

   localparam int CNT_W = $clog2(NUM_ROUNDS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - 1);

   state_t            r_state, w_state_nx;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
   logic [KEY_W-1:0]  r_rk, w_rk_nx;
   logic [DATA_W-1:0] r_data, w_data_nx;
   logic [DATA_W-1:0] w_r1;
   logic [KEY_W-1:0]  w_rk1;

   assign w_rk1 = {r_rk[KEY_W-2:0], r_rk[KEY_W-1]};

   round_fn #(.DATA_W(DATA_W), .KEY_W(KEY_W)) u_rf0 (
      .i_state (r_data),
      .i_rk    (r_rk),
      .o_state (w_r1)
   );

`ifdef ROUND_ENGINE_UNROLL2_EN
   localparam logic [CNT_W-1:0] LAST2 = CNT_W'(NUM_ROUNDS - 2);
   logic [DATA_W-1:0] w_r2;
   logic [KEY_W-1:0]  w_rk2;

   assign w_rk2 = {r_rk[KEY_W-3:0], r_rk[KEY_W-1:KEY_W-2]};

   round_fn #(.DATA_W(DATA_W), .KEY_W(KEY_W)) u_rf1 (
      .i_state (w_r1),
      .i_rk    (w_rk1),
      .o_state (w_r2)
   );
`endif

   // Next-state and datapath update; hold everything by default
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_rk_nx    = r_rk;
      w_data_nx  = r_data;
      unique case (r_state)
         S_IDLE: begin
            if (IN_VALID) begin
               w_data_nx  = D_IN;
               w_rk_nx    = K_IN;
               w_cnt_nx   = '0;
               w_state_nx = S_RUN;
            end
         end
         S_RUN: begin
`ifdef ROUND_ENGINE_UNROLL2_EN
            if (r_cnt == LAST) begin
               w_data_nx  = w_r1;
               w_rk_nx    = w_rk1;
               w_cnt_nx   = r_cnt + CNT_W'(1);
               w_state_nx = S_DONE;
            end else begin
               w_data_nx = w_r2;
               w_rk_nx   = w_rk2;
               w_cnt_nx  = r_cnt + CNT_W'(2);
               if (r_cnt == LAST2)
                  w_state_nx = S_DONE;
            end
`else
            w_data_nx = w_r1;
            w_rk_nx   = w_rk1;
            w_cnt_nx  = r_cnt + CNT_W'(1);
            if (r_cnt == LAST)
               w_state_nx = S_DONE;
`endif
         end
         S_DONE: begin
            if (OUT_READY)
               w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State, counter, key and data registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rk    <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_rk    <= w_rk_nx;
         r_data  <= w_data_nx;
      end
   end

   assign IN_READY  = (r_state == S_IDLE);
   assign OUT_VALID = (r_state == S_DONE);
   assign BUSY      = (r_state == S_RUN);
   assign D_OUT     = r_data;

endmodule
